// File: rtl/snoop_bus_if.sv
// Snoop bus bundle between the per-core cache requesters and the arbiter.
// slave = arbiter side, master = requester/responder side.
interface snoop_bus_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32
);
  logic [NUM_CORES-1:0]        Req;
  logic [2*NUM_CORES-1:0]      Req_type;
  logic [ADDR_W*NUM_CORES-1:0] Req_addr;
  logic [NUM_CORES-1:0]        Snoop_shared;
  logic                        Mem_done;
  logic [NUM_CORES-1:0]        Grant;
  logic                        BusRd;
  logic                        BusRdX;
  logic                        Invalidate;
  logic [ADDR_W-1:0]           Address_Com;
  logic                        Shared;
  logic                        Bus_done;
  logic                        Bus_err;

  modport slave (
    input  Req, Req_type, Req_addr,
    input  Snoop_shared, Mem_done,
    output Grant, BusRd, BusRdX, Invalidate,
    output Address_Com, Shared,
    output Bus_done, Bus_err
  );

  modport master (
    output Req, Req_type, Req_addr,
    output Snoop_shared, Mem_done,
    input  Grant, BusRd, BusRdX, Invalidate,
    input  Address_Com, Shared,
    input  Bus_done, Bus_err
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter: IDLE -> BCAST -> (WAIT) -> DONE.
// Define SNOOP_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES (Bus_err).
module snoop_bus_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic        clk,
  input logic        rst_n,
  snoop_bus_if.slave bus
);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [1:0] T_RD  = 2'b01;
  localparam logic [1:0] T_RDX = 2'b10;
  localparam logic [1:0] T_INV = 2'b11;

  typedef enum logic [1:0] {IDLE, BCAST, WAIT, DONE} state_t;

  state_t               state, state_nx;
  logic [IW-1:0]        ptr, idx, sel;
  logic [1:0]           typ;
  logic [ADDR_W-1:0]    addr;
  logic                 shared_q, err_q;
  logic                 any, timeout;
  logic [NUM_CORES-1:0] elig, own;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++)
      elig[i] = bus.Req[i] && (bus.Req_type[2*i +: 2] != 2'b00);
  end

  // first eligible core at or after ptr, wrapping
  always_comb begin
    logic [IW:0] pk;
    sel = '0;
    any = 1'b0;
    pk  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      pk = {1'b0, ptr} + (IW+1)'(k);
      if (pk >= (IW+1)'(NUM_CORES))
        pk = pk - (IW+1)'(NUM_CORES);
      if (!any && elig[pk[IW-1:0]]) begin
        any = 1'b1;
        sel = pk[IW-1:0];
      end
    end
  end

  assign own = NUM_CORES'(1) << idx;

`ifdef SNOOP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wcnt <= '0;
    else if (state != WAIT)
      wcnt <= '0;
    else
      wcnt <= wcnt + CW'(1);
  end

  assign timeout = (state == WAIT) &&
                   (wcnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (any) state_nx = BCAST;
      BCAST: state_nx = (typ == T_INV) ? DONE : WAIT;
      WAIT:  if (bus.Mem_done || timeout) state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      typ      <= 2'b00;
      addr     <= '0;
      shared_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (any) begin
          idx  <= sel;
          typ  <= bus.Req_type[2*sel +: 2];
          addr <= bus.Req_addr[ADDR_W*sel +: ADDR_W];
        end
        BCAST: begin
          shared_q <= |(bus.Snoop_shared & ~own);
          err_q    <= 1'b0;
        end
        // Mem_done beats a coincident timeout
        WAIT: if (!bus.Mem_done && timeout) begin
          err_q    <= 1'b1;
          shared_q <= 1'b0;
        end
        DONE:
          ptr <= (idx == IW'(NUM_CORES - 1)) ? '0 : idx + IW'(1);
      endcase
    end
  end

  always_comb begin
    bus.Grant       = '0;
    bus.Address_Com = '0;
    bus.BusRd       = 1'b0;
    bus.BusRdX      = 1'b0;
    bus.Invalidate  = 1'b0;
    bus.Shared      = 1'b0;
    bus.Bus_done    = 1'b0;
    bus.Bus_err     = 1'b0;
    if (state != IDLE) begin
      bus.Grant       = own;
      bus.Address_Com = addr;
    end
    if (state == BCAST) begin
      bus.BusRd      = (typ == T_RD);
      bus.BusRdX     = (typ == T_RDX);
      bus.Invalidate = (typ == T_INV);
    end
    if (state == DONE) begin
      bus.Bus_done = 1'b1;
      bus.Shared   = shared_q;
      bus.Bus_err  = err_q;
    end
  end
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: directed table, corner sequences
// and random transactions against a transaction-level model.
module tb_snoop_bus_arbiter;
  localparam int NC = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  int   m_ptr = 0;

  always #5 clk = ~clk;

  snoop_bus_if #(.NUM_CORES(NC), .ADDR_W(AW)) bus();

  snoop_bus_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  types;
    logic [31:0] base;
    logic [3:0]  snoop;
    int          nwait;
    logic [3:0]  eg;
    logic [2:0]  es;
    logic        esh;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_grant(
      input logic [3:0] req, input logic [7:0] types, input int ptr);
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (ptr + k) % NC;
      if (req[c] && types[2*c +: 2] != 2'b00) return 4'(1 << c);
    end
    return 4'b0000;
  endfunction

  function automatic logic [2:0] strobe_of(input logic [1:0] t);
    case (t)
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int core_of(input logic [3:0] g);
    for (int c = 0; c < NC; c++) if (g[c]) return c;
    return 0;
  endfunction

  function automatic logic [127:0] mk_addrs(input logic [31:0] base);
    logic [127:0] a;
    for (int i = 0; i < NC; i++) a[32*i +: 32] = base + 32'(i) * 32'h100;
    return a;
  endfunction

  task automatic run_txn(
      input logic [3:0] req, input logic [7:0] types,
      input logic [127:0] addrs, input logic [3:0] snoop,
      input int nwait, input logic [3:0] eg, input logic [2:0] es,
      input logic esh, input logic [31:0] ea);
    int cyc;
    int lat;
    bit done;
    bus.Req = req;
    bus.Req_type = types;
    bus.Req_addr = addrs;
    bus.Mem_done = 1'b1;
    bus.Snoop_shared = 4'hF;
    chk("idle_outs", 64'({bus.Grant, bus.BusRd, bus.BusRdX,
        bus.Invalidate, bus.Bus_done, bus.Shared, bus.Address_Com}), 64'(0));
    if (eg == 4'b0000) begin
      repeat (4) begin
        step;
        chk("no_grant", 64'({bus.Grant, bus.BusRd, bus.BusRdX,
            bus.Invalidate, bus.Bus_done}), 64'(0));
      end
      bus.Req = '0;
      bus.Mem_done = 1'b0;
      return;
    end
    step;
    chk("bcast_grant", 64'(bus.Grant), 64'(eg));
    chk("bcast_strobe", 64'({bus.BusRd, bus.BusRdX, bus.Invalidate}), 64'(es));
    chk("bcast_addr", 64'(bus.Address_Com), 64'(ea));
    chk("bcast_done", 64'({bus.Bus_done, bus.Shared}), 64'(0));
    bus.Snoop_shared = snoop;
    bus.Req_addr = ~addrs;
    bus.Req_type = ~types;
    bus.Req = ~req;
    cyc = 2;
    done = 1'b0;
    while (!done && cyc < 3 + nwait + 8) begin
      step;
      cyc++;
      bus.Snoop_shared = ~snoop;
      if (bus.Bus_done) done = 1'b1;
      else begin
        chk("wait_hold", 64'({bus.Grant, bus.Address_Com, bus.BusRd,
            bus.BusRdX, bus.Invalidate, bus.Shared}), 64'({eg, ea, 4'b0}));
        bus.Mem_done = (cyc - 2 == nwait);
      end
    end
    lat = (es == 3'b001) ? 3 : 3 + nwait;
    chk("done_seen", 64'(done), 64'(1));
    chk("latency", 64'(cyc), 64'(lat));
    chk("done_outs", 64'({bus.Grant, bus.Address_Com, bus.Shared,
        bus.Bus_err, bus.BusRd, bus.BusRdX, bus.Invalidate}),
        64'({eg, ea, esh, 1'b0, 3'b000}));
    bus.Mem_done = 1'b0;
    step;
    bus.Req = '0;
    chk("post_idle", 64'({bus.Grant, bus.Address_Com, bus.Bus_done,
        bus.Shared}), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int waits;
    bus.Req = '0;
    bus.Req_type = '0;
    bus.Req_addr = '0;
    bus.Snoop_shared = '0;
    bus.Mem_done = 1'b0;

    tbl.push_back('{4'b0010, 8'h04, 32'h0F40, 4'b0100, 2, 4'b0010, 3'b100, 1'b1, 32'h1040});
    tbl.push_back('{4'b0100, 8'h30, 32'h2000, 4'b0100, 0, 4'b0100, 3'b001, 1'b0, 32'h2200});
    tbl.push_back('{4'b0001, 8'h00, 32'h0000, 4'b0000, 0, 4'b0000, 3'b000, 1'b0, 32'h0});
    tbl.push_back('{4'b1000, 8'h80, 32'h3000, 4'b0111, 3, 4'b1000, 3'b010, 1'b1, 32'h3300});
    tbl.push_back('{4'b0001, 8'h00, 32'h0000, 4'b0000, 0, 4'b0000, 3'b000, 1'b0, 32'h0});
    tbl.push_back('{4'b1111, 8'hAA, 32'h4000, 4'b0001, 1, 4'b0001, 3'b010, 1'b0, 32'h4000});
    tbl.push_back('{4'b1111, 8'hAA, 32'h4000, 4'b0001, 1, 4'b0010, 3'b010, 1'b1, 32'h4100});
    tbl.push_back('{4'b1111, 8'hAA, 32'h4000, 4'b0000, 1, 4'b0100, 3'b010, 1'b0, 32'h4200});
    tbl.push_back('{4'b1111, 8'hAA, 32'h4000, 4'b1000, 1, 4'b1000, 3'b010, 1'b0, 32'h4300});
    tbl.push_back('{4'b1111, 8'h55, 32'h5000, 4'b0000, 1, 4'b0001, 3'b100, 1'b0, 32'h5000});
    tbl.push_back('{4'b1111, 8'h72, 32'h6000, 4'b1011, 0, 4'b0100, 3'b001, 1'b1, 32'h6200});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 64'({bus.Grant, bus.BusRd, bus.BusRdX, bus.Invalidate,
        bus.Address_Com, bus.Shared, bus.Bus_done, bus.Bus_err}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    step;

    foreach (tbl[i]) begin
      run_txn(tbl[i].req, tbl[i].types, mk_addrs(tbl[i].base),
              tbl[i].snoop, tbl[i].nwait, tbl[i].eg, tbl[i].es,
              tbl[i].esh, tbl[i].ea);
      if (tbl[i].eg != 4'b0000) m_ptr = (core_of(tbl[i].eg) + 1) % NC;
    end

    // abort a core3 read in WAIT; pointer was 3 before reset
    bus.Req = 4'b1000;
    bus.Req_type = 8'h40;
    bus.Req_addr = {32'hDEAD_0000, 96'h0};
    bus.Mem_done = 1'b0;
    step;
    chk("rst_bcast", 64'(bus.Grant), 64'(4'b1000));
    step;
    chk("rst_wait", 64'({bus.Grant, bus.Address_Com}), 64'({4'b1000, 32'hDEAD_0000}));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 64'({bus.Grant, bus.Address_Com, bus.Bus_done,
        bus.BusRd, bus.Shared}), 64'(0));
    bus.Req = '0;
    @(posedge clk);
    #1;
    chk("rst_no_done", 64'({bus.Bus_done, bus.Grant}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    step;
    m_ptr = 0;
    run_txn(4'b1111, 8'hAA, mk_addrs(32'h7000), 4'b0000, 1,
            4'b0001, 3'b010, 1'b0, 32'h7000);
    run_txn(4'b1000, 8'h40, mk_addrs(32'h8000), 4'b0001, 2,
            4'b1000, 3'b100, 1'b1, 32'h8300);
    m_ptr = 0;

    for (int t = 0; t < 30; t++) begin
      logic [3:0]   r, sn, eg;
      logic [7:0]   ty;
      logic [127:0] ad;
      logic [2:0]   es;
      logic [31:0]  ea;
      logic         esh;
      int           nw, w;
      r  = 4'($urandom);
      ty = 8'($urandom);
      ad = {$urandom, $urandom, $urandom, $urandom};
      sn = 4'($urandom);
      nw = $urandom_range(1, 4);
      eg = model_grant(r, ty, m_ptr);
      es = 3'b000;
      ea = '0;
      esh = 1'b0;
      if (eg != 4'b0000) begin
        w  = core_of(eg);
        es = strobe_of(ty[2*w +: 2]);
        ea = ad[32*w +: 32];
        for (int c = 0; c < NC; c++) if (c != w && sn[c]) esh = 1'b1;
        m_ptr = (w + 1) % NC;
      end
      run_txn(r, ty, ad, sn, nw, eg, es, esh, ea);
    end

    // read with no responder
    bus.Req = 4'b0001;
    bus.Req_type = 8'h01;
    bus.Req_addr = mk_addrs(32'h9000);
    bus.Mem_done = 1'b0;
    step;
    bus.Snoop_shared = 4'b1111;
    step;
`ifdef SNOOP_TIMEOUT_EN
    waits = 1;
    while (waits < 40) begin
      step;
      if (bus.Bus_done) break;
      waits++;
    end
    chk("to_waits", 64'(waits), 64'(8));
    chk("to_outs", 64'({bus.Bus_done, bus.Bus_err, bus.Shared}), 64'(3'b110));
    step;
    bus.Req = '0;
    bad = 0;
`else
    bad = 0;
    waits = 0;
    repeat (100) begin
      step;
      waits++;
      if (bus.Grant != 4'b0001 || bus.Bus_done) bad++;
    end
    chk("hold_100", 64'(bad), 64'(0));
    bus.Mem_done = 1'b1;
    step;
    bus.Mem_done = 1'b0;
    chk("hold_done", 64'({bus.Bus_done, bus.Bus_err, bus.Shared}), 64'(3'b101));
    step;
    bus.Req = '0;
`endif
    step;
    chk("final_idle", 64'({bus.Grant, bus.Bus_done}), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
